mmu_line_fetcher: RTL and testbench

// - Responder side of the L1<->MMU line-read interface: accepts a level read request from
//   the L1 cache, fetches one 32B line (8 words) or one MMIO word from 32-bit backing memory.
// - Returns the result on a 256-bit bus with a one-cycle done pulse.
// - Sits between the L1 caches and the memory/MMIO bus port.

---
 rtl/mmu_line_fetcher.sv | 203 ++++++++++++++++++++
 tb/tb_mmu_line_fetcher.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_line_fetcher.sv
// ============================================================================
// Module      : mmu_line_fetcher
// Description : Responder side of the L1<->MMU line-read interface. Accepts a
//               level read request from the L1 cache, fetches one 32-byte
//               line (8 words) or one MMIO word from 32-bit backing memory
//               with a single outstanding read, and returns the result on a
//               256-bit bus with a one-cycle done pulse.
// Option      : MMU_FILL_STATS_EN - when defined, adds the fill/MMIO/busy
//               statistics counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mmu_line_fetcher #(
  parameter logic [3:0] MMIO_TAG   = 4'hF,
  parameter int         LINE_WORDS = 8
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  // L1 request side
  input  logic                       l1_mmu_req_read,
  input  logic [31:0]                l1_mmu_req_addr,
  output logic                       mmu_l1_done,
  output logic [LINE_WORDS*32-1:0]   mmu_l1_read_data,
  // Memory / MMIO bus side
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ready,
  input  logic                       mem_rvalid,
`ifdef MMU_FILL_STATS_EN
  output logic [31:0]                stat_fills,
  output logic [31:0]                stat_mmio,
  output logic [31:0]                stat_busy,
`endif
  input  logic [31:0]                mem_rdata
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  // The beat counter covers address bits [4:2]; the line is fixed at 8 words.
  localparam int         BEAT_W    = 3;
  localparam logic [BEAT_W-1:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  logic [2:0]                   state_q,    state_d;
  logic [BEAT_W-1:0]            beat_q,     beat_d;
  logic                         mmio_q,     mmio_d;
  logic [31:0]                  base_q,     base_d;
  logic [LINE_WORDS-1:0][31:0]  line_q,     line_d;
  logic                         mem_req_q,  mem_req_d;
  logic [31:0]                  mem_addr_q, mem_addr_d;
  logic                         done_q,     done_d;

  // Request decode: MMIO goes out as a single aligned word, cached reads
  // are aligned down to the 32-byte line.
  logic        req_is_mmio;
  logic [31:0] req_base;
  logic        unused_addr_bits;

  assign req_is_mmio      = (l1_mmu_req_addr[31:28] == MMIO_TAG);
  assign req_base         = req_is_mmio ? {l1_mmu_req_addr[31:2], 2'b00}
                                        : {l1_mmu_req_addr[31:5], 5'b0_0000};
  // Byte-lane bits never reach the memory bus.
  assign unused_addr_bits = ^l1_mmu_req_addr[1:0];

  // Next-state logic for the fetch sequencer and line buffer
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mmio_d  = mmio_q;
    base_d  = base_q;
    line_d  = line_q;

    case (state_q)
      S_IDLE: begin
        if (l1_mmu_req_read) begin
          // Latch the address now; later changes on the request bus are
          // deliberately ignored for the rest of the fetch.
          mmio_d  = req_is_mmio;
          base_d  = req_base;
          line_d  = '0;
          beat_d  = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          line_d[beat_q] = mem_rdata;
          if (mmio_q || (beat_q == LAST_BEAT)) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_DONE: begin
        state_d = S_HOLD;
      end

      // The requester drops its registered request one cycle after done;
      // this cycle swallows that lingering level so it is not a new fetch.
      S_HOLD: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered bus outputs derived from the upcoming state
  always_comb begin
    mem_req_d  = (state_d == S_REQ);
    mem_addr_d = mem_addr_q;
    if (state_d == S_REQ) begin
      // The beat only ever replaces bits [4:2], so no carry into the tag.
      mem_addr_d = {base_d[31:5], base_d[4:2] + beat_d, 2'b00};
    end
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      mmio_q     <= 1'b0;
      base_q     <= '0;
      line_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mmio_q     <= mmio_d;
      base_q     <= base_d;
      line_q     <= line_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
    end
  end

  assign mem_req          = mem_req_q;
  assign mem_addr         = mem_addr_q;
  assign mmu_l1_done      = done_q;
  assign mmu_l1_read_data = line_q;

`ifdef MMU_FILL_STATS_EN
  // --------------------------------------------------------------------------
  // Fill statistics; all counters wrap naturally at 2^32.
  // --------------------------------------------------------------------------
  logic [31:0] fills_q, mmio_cnt_q, busy_q;

  // Count completed line fills, MMIO reads and cycles spent outside IDLE
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      fills_q    <= '0;
      mmio_cnt_q <= '0;
      busy_q     <= '0;
    end else begin
      if (state_q != S_IDLE) begin
        busy_q <= busy_q + 32'd1;
      end
      if (state_q == S_DONE) begin
        if (mmio_q) begin
          mmio_cnt_q <= mmio_cnt_q + 32'd1;
        end else begin
          fills_q    <= fills_q + 32'd1;
        end
      end
    end
  end

  assign stat_fills = fills_q;
  assign stat_mmio  = mmio_cnt_q;
  assign stat_busy  = busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmu_line_fetcher.sv
// ============================================================================
// Module      : tb_mmu_line_fetcher
// Description : Scoreboard bench for mmu_line_fetcher. A driver issues L1
//               requests and pushes the expected line and address sequence;
//               a memory responder and a done monitor compare independently.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mmu_line_fetcher;

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic         l1_mmu_req_read = 1'b0;
  logic [31:0]  l1_mmu_req_addr = '0;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
`ifdef MMU_FILL_STATS_EN
  logic [31:0]  stat_fills, stat_mmio, stat_busy;
`endif

  always #5 sys_clk = ~sys_clk;

  mmu_line_fetcher dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .l1_mmu_req_read  (l1_mmu_req_read),
    .l1_mmu_req_addr  (l1_mmu_req_addr),
    .mmu_l1_done      (mmu_l1_done),
    .mmu_l1_read_data (mmu_l1_read_data),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ready        (mem_ready),
    .mem_rvalid       (mem_rvalid),
`ifdef MMU_FILL_STATS_EN
    .stat_fills       (stat_fills),
    .stat_mmio        (stat_mmio),
    .stat_busy        (stat_busy),
`endif
    .mem_rdata        (mem_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int dones = 0;
  int issued = 0;

  // Backing memory contents: word at address a is a ^ key.
  logic [31:0] key = '0;

  logic [255:0] exp_data_q[$];
  logic [31:0]  exp_addr_q[$];

  // Responder configuration
  int stall_n = 0;
  bit rand_stall = 1'b0;
  int max_dly = 0;
  bit spur_en = 1'b0;

  // Responder state
  bit          pend = 1'b0;
  int          pend_dly = 0;
  logic [31:0] pend_addr = '0;
  int          stall_cnt = 0;
  bit          s_req = 1'b0;
  logic [31:0] s_addr = '0;

  // Expected statistics since the last reset
  int exp_fills = 0;
  int exp_mmio = 0;
  int exp_busy = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    l = '0;
    if (is_mmio(a)) begin
      l[31:0] = mem_word(a & ~32'h3);
    end else begin
      base = a & ~32'h1F;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(base + 32'(4 * i));
    end
    return l;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_expect(input logic [31:0] a);
    logic [31:0] base;
    exp_data_q.push_back(model_line(a));
    if (is_mmio(a)) begin
      exp_addr_q.push_back(a & ~32'h3);
    end else begin
      base = a & ~32'h1F;
      for (int i = 0; i < 8; i++) exp_addr_q.push_back(base + 32'(4 * i));
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Memory responder, drive half: sample DUT outputs and drive bus inputs
  initial forever begin
    @(negedge sys_clk);
    s_req  = mem_req;
    s_addr = mem_addr;
    if (pend) begin
      if (pend_dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        pend_dly--;
      end
    end else begin
      mem_rvalid = spur_en && ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
    end
    if (mem_req) begin
      if (stall_cnt < stall_n) begin
        mem_ready = 1'b0;
        stall_cnt++;
      end else begin
        mem_ready = 1'b1;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  end

  // Memory responder, commit half: handshakes take effect on the clock edge
  initial forever begin
    @(posedge sys_clk);
    if (rst) begin
      pend = 1'b0;
      stall_cnt = 0;
    end else begin
      if (pend && mem_rvalid) pend = 1'b0;
      if (s_req && mem_ready) begin
        accepts++;
        check("single outstanding read", 256'(pend), 256'(0));
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_addr: unexpected request at %h", s_addr);
        end else begin
          check("mem_addr order", 256'(s_addr), 256'(exp_addr_q.pop_front()));
        end
        pend      = 1'b1;
        pend_addr = s_addr;
        pend_dly  = $urandom_range(0, max_dly);
        stall_cnt = 0;
        if (rand_stall) stall_n = $urandom_range(0, 3);
      end
    end
  end

  // Done monitor: every pulse must match the oldest outstanding expectation
  initial forever begin
    @(negedge sys_clk);
    if (!rst && mmu_l1_done) begin
      dones++;
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done pulse: unexpected done with data %h", mmu_l1_read_data);
      end else begin
        check("line data", mmu_l1_read_data, exp_data_q.pop_front());
      end
    end
  end

  // One complete fetch; exp_lat < 0 skips the latency check.
  task automatic fetch(input logic [31:0] a, input bit wiggle, input bit drop, input int exp_lat);
    int c0;
    bit got;
    logic [255:0] exp;
    got = 1'b0;
    exp = model_line(a);
    @(negedge sys_clk);
    push_expect(a);
    issued++;
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = a;
    c0 = cyc;
    @(negedge sys_clk);
    check("buffer cleared on accept", mmu_l1_read_data, '0);
    for (int k = 0; k < 3000; k++) begin
      if (mmu_l1_done) begin
        got = 1'b1;
        break;
      end
      @(negedge sys_clk);
      if (wiggle) l1_mmu_req_addr = $urandom;
      if (drop) l1_mmu_req_read = 1'b0;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done timeout: no done for addr %h", a);
      l1_mmu_req_read = 1'b0;
      return;
    end
    if (exp_lat >= 0) check("req to done latency", 256'(cyc - c0), 256'(exp_lat));
    exp_busy += cyc - c0 + 1;
    if (is_mmio(a)) exp_mmio++; else exp_fills++;
    // Request lingers through the cycle after done.
    @(negedge sys_clk);
    check("mem_req low in hold", 256'(mem_req), 256'(0));
    l1_mmu_req_read = 1'b0;
    @(negedge sys_clk);
    check("data held after done", mmu_l1_read_data, exp);
    @(negedge sys_clk);
    check("no refetch from lingering req", 256'(mem_req), 256'(0));
  endtask

  // Start a line fetch and reset once beat 4 has been issued.
  task automatic abort_at_beat4(input logic [31:0] a);
    int a0;
    bit hit;
    hit = 1'b0;
    @(negedge sys_clk);
    push_expect(a);
    l1_mmu_req_read = 1'b1;
    l1_mmu_req_addr = a;
    a0 = accepts;
    for (int k = 0; k < 3000; k++) begin
      @(negedge sys_clk);
      if (accepts - a0 >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort setup: beat 4 never issued, accepts %0d", accepts - a0);
    end
    rst = 1'b1;
    l1_mmu_req_read = 1'b0;
    void'(exp_data_q.pop_back());
    exp_addr_q.delete();
    exp_fills = 0;
    exp_mmio  = 0;
    exp_busy  = 0;
    @(negedge sys_clk);
    check("abort done", 256'(mmu_l1_done), 256'(0));
    check("abort mem_req", 256'(mem_req), 256'(0));
    check("abort data", mmu_l1_read_data, '0);
    check("abort mem_addr", 256'(mem_addr), 256'(0));
    rst = 1'b0;
    repeat (6) @(negedge sys_clk);
    check("idle after abort", 256'(mem_req), 256'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset done", 256'(mmu_l1_done), 256'(0));
    check("reset mem_req", 256'(mem_req), 256'(0));
    check("reset mem_addr", 256'(mem_addr), 256'(0));
    check("reset data", mmu_l1_read_data, '0);
    rst = 1'b0;

    // Directed line fetch: rdata = address, 18 cycles inclusive (17 edges).
    key = '0;
    fetch(32'h0000_1234, 1'b0, 1'b0, 17);

    // Directed MMIO word: 4 cycles inclusive (3 edges).
    key = 32'hDEAD_BEEF ^ 32'hF000_0008;
    fetch(32'hF000_0008, 1'b0, 1'b0, 3);

    // Stalled ready, random rvalid delay, spurious rvalid, address wiggle, early drop.
    stall_n = 3;
    max_dly = 5;
    spur_en = 1'b1;
    key = $urandom;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      a[31:28] = 4'h0;
      fetch(a, i == 1, i == 2, -1);
    end

    // Reset at beat 4, then a fresh fetch; stats restart from here.
    stall_n = 0;
    max_dly = 2;
    abort_at_beat4(32'h0000_2040);
    fetch(32'h0000_2044, 1'b0, 1'b0, -1);
    fetch(32'h0123_4560, 1'b0, 1'b0, -1);
    fetch(32'hF00F_0104, 1'b0, 1'b0, -1);
`ifdef MMU_FILL_STATS_EN
    check("stat_fills", 256'(stat_fills), 256'(exp_fills));
    check("stat_mmio", 256'(stat_mmio), 256'(exp_mmio));
    check("stat_busy", 256'(stat_busy), 256'(exp_busy));
`endif

    // Random mix of lines and MMIO words.
    rand_stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      max_dly = $urandom_range(0, 5);
      key = $urandom;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'hF;
      else if (a[31:28] == 4'hF) a[31:28] = 4'h7;
      fetch(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), -1);
    end

    repeat (10) @(negedge sys_clk);
    check("scoreboard drained", 256'(exp_data_q.size()), 256'(0));
    check("address queue drained", 256'(exp_addr_q.size()), 256'(0));
    check("done pulse count", 256'(dones), 256'(issued));
`ifdef MMU_FILL_STATS_EN
    check("final stat_fills", 256'(stat_fills), 256'(exp_fills));
    check("final stat_mmio", 256'(stat_mmio), 256'(exp_mmio));
    check("final stat_busy", 256'(stat_busy), 256'(exp_busy));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
